vga_pattern_gen: RTL and testbench

- Pixel-colour stage directly downstream of the VGA timing generator.
- Consumes the generator's pixel counters, display-enable and frame-start pulse; produces the 3-bit RGB pixel value one clock later.
- Provides four selectable test patterns: colour bars, checkerboard, bouncing box, vertical stripes.
- A debounced push-button cycles the pattern; a new pattern takes effect only at a frame boundary, so frames never tear.

---
 rtl/vga_pattern_gen.sv | 131 +++++++++++++
 tb/tb_vga_pattern_gen.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/vga_pattern_gen.sv
// Pixel-colour stage behind the VGA timing generator: four test patterns, one-clock
// registered rgb, button-selected pattern that switches only at frame boundaries.
module vga_pattern_gen #(
  parameter int H_SIZE          = 800,
  parameter int V_SIZE          = 600,
  parameter int BOX_SIZE        = 32,
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [10:0] h_count,
  input  logic [9:0]  v_count,
  input  logic        video_on,
  input  logic        frame_start,
  input  logic        mode_btn,
  output logic [2:0]  rgb,
  output logic [1:0]  mode
);

  localparam int          BAR_W  = H_SIZE / 8;
  localparam int          CNT_W  = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [10:0] BX_MAX = 11'(H_SIZE - BOX_SIZE);
  localparam logic [9:0]  BY_MAX = 10'(V_SIZE - BOX_SIZE);

  logic [1:0]       sync_ff;
  logic             btn_state;
  logic [CNT_W-1:0] db_cnt;
  logic             accept;
  logic             press;
  logic [1:0]       pending_mode;

  logic [10:0] bx;
  logic [9:0]  by;
  logic        dx_neg;
  logic        dy_neg;

  logic [10:0] bar_idx;
  logic [2:0]  bar_rgb;
  logic [11:0] bx_end;
  logic [10:0] by_end;
  logic        in_box;
  logic [2:0]  pix;

  // A press is accepted on the clock where btn_state would rise.
  assign accept = (sync_ff[1] != btn_state) && (db_cnt == CNT_W'(DEBOUNCE_CYCLES - 1));
  assign press  = accept && sync_ff[1];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_ff   <= 2'b00;
      btn_state <= 1'b0;
      db_cnt    <= '0;
    end else begin
      sync_ff <= {sync_ff[0], mode_btn};
      if (sync_ff[1] != btn_state) begin
        if (accept) begin
          btn_state <= sync_ff[1];
          db_cnt    <= '0;
        end else begin
          db_cnt <= db_cnt + 1'b1;
        end
      end else begin
        db_cnt <= '0;
      end
    end
  end

  // mode samples pending_mode before any same-clock press, so such a press waits a frame.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pending_mode <= 2'd0;
      mode         <= 2'd0;
    end else begin
      if (press) pending_mode <= pending_mode + 2'd1;
      if (frame_start) mode <= pending_mode;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bx     <= 11'd0;
      by     <= 10'd0;
      dx_neg <= 1'b0;
      dy_neg <= 1'b0;
    end else if (frame_start) begin
      if (!dx_neg && bx == BX_MAX) begin
        dx_neg <= 1'b1;
        bx     <= bx - 11'd1;
      end else if (dx_neg && bx == 11'd0) begin
        dx_neg <= 1'b0;
        bx     <= 11'd1;
      end else begin
        bx <= dx_neg ? bx - 11'd1 : bx + 11'd1;
      end
      if (!dy_neg && by == BY_MAX) begin
        dy_neg <= 1'b1;
        by     <= by - 10'd1;
      end else if (dy_neg && by == 10'd0) begin
        dy_neg <= 1'b0;
        by     <= 10'd1;
      end else begin
        by <= dy_neg ? by - 10'd1 : by + 10'd1;
      end
    end
  end

  assign bar_idx = h_count / 11'(BAR_W);
  assign bar_rgb = (bar_idx > 11'd7) ? 3'd7 : bar_idx[2:0];
  assign bx_end  = {1'b0, bx} + 12'(BOX_SIZE - 1);
  assign by_end  = {1'b0, by} + 11'(BOX_SIZE - 1);
  assign in_box  = ({1'b0, h_count} >= {1'b0, bx}) && ({1'b0, h_count} <= bx_end) &&
                   ({1'b0, v_count} >= {1'b0, by}) && ({1'b0, v_count} <= by_end);

  always_comb begin
    pix = 3'b000;
    if (video_on) begin
      case (mode)
        2'd0:    pix = bar_rgb;
        2'd1:    pix = {3{h_count[5] ^ v_count[5]}};
        2'd2:    pix = in_box ? 3'b111 : 3'b001;
        default: pix = v_count[8:6];
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) rgb <= 3'b000;
    else        rgb <= pix;
  end

endmodule

// File: tb/tb_vga_pattern_gen.sv
// Directed bench for vga_pattern_gen with a short debounce window so presses take a few clocks.
module tb_vga_pattern_gen;

  logic        clk = 1'b0;
  logic        reset;
  logic [10:0] h_count;
  logic [9:0]  v_count;
  logic        video_on;
  logic        frame_start;
  logic        mode_btn;
  logic [2:0]  rgb;
  logic [1:0]  mode;

  int pass_count  = 0;
  int check_count = 0;

  vga_pattern_gen #(
    .H_SIZE(800), .V_SIZE(600), .BOX_SIZE(32), .DEBOUNCE_CYCLES(4)
  ) dut (
    .clk(clk), .reset(reset), .h_count(h_count), .v_count(v_count),
    .video_on(video_on), .frame_start(frame_start), .mode_btn(mode_btn),
    .rgb(rgb), .mode(mode)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [11:0] observed, input logic [11:0] expected);
    check_count++;
    assert (observed === expected) pass_count++;
    else $error("FAIL %s: observed %0d expected %0d", tag, observed, expected);
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pix(input string tag, input int h, input int v, input logic on, input logic [2:0] expected);
    h_count  = 11'(h);
    v_count  = 10'(v);
    video_on = on;
    step(1);
    check(tag, 12'(rgb), 12'(expected));
  endtask

  task automatic press_btn();
    mode_btn = 1'b1;
    step(10);
    mode_btn = 1'b0;
    step(10);
  endtask

  task automatic frame_pulse();
    frame_start = 1'b1;
    step(1);
    frame_start = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    step(2);
    reset = 1'b1;
    step(1);
  endtask

  initial begin
    reset = 1'b0; h_count = '0; v_count = '0; video_on = 1'b0;
    frame_start = 1'b0; mode_btn = 1'b0;
    step(2);
    check("reset_rgb", 12'(rgb), 12'd0);
    check("reset_mode", 12'(mode), 12'd0);
    check("reset_bx", 12'(dut.bx), 12'd0);
    check("reset_by", 12'(dut.by), 12'd0);
    reset = 1'b1;
    step(1);

    pix("bars_h250", 250, 10, 1'b1, 3'b010);
    pix("bars_h0",   0,   10, 1'b1, 3'b000);
    pix("bars_h799", 799, 10, 1'b1, 3'b111);
    pix("bars_blank", 250, 10, 1'b0, 3'b000);

    mode_btn = 1'b1;
    step(3);
    mode_btn = 1'b0;
    step(8);
    check("short_press_pending", 12'(dut.pending_mode), 12'd0);
    frame_pulse();
    check("short_press_mode", 12'(mode), 12'd0);

    mode_btn = 1'b1;
    step(12);
    mode_btn = 1'b0;
    step(10);
    check("long_press_pending", 12'(dut.pending_mode), 12'd1);
    frame_pulse();
    check("long_press_mode", 12'(mode), 12'd1);
    pix("checker_32_0",  32, 0,  1'b1, 3'b111);
    pix("checker_32_32", 32, 32, 1'b1, 3'b000);
    pix("checker_0_32",  0,  32, 1'b1, 3'b111);

    press_btn();
    press_btn();
    check("accum_mode_before_frame", 12'(mode), 12'd1);
    frame_pulse();
    check("accum_mode_1_to_3", 12'(mode), 12'd3);
    pix("stripes_v64",  100, 64,  1'b1, 3'b001);
    pix("stripes_v448", 100, 448, 1'b1, 3'b111);
    pix("stripes_blank", 100, 448, 1'b0, 3'b000);

    do_reset();
    press_btn();
    press_btn();
    frame_pulse();
    check("accum_mode_0_to_2", 12'(mode), 12'd2);
    pix("box_before_reset", 1, 1, 1'b1, 3'b111);
    reset = 1'b0;
    #1;
    check("async_reset_rgb", 12'(rgb), 12'd0);
    check("async_reset_mode", 12'(mode), 12'd0);
    #2;
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("post_reset_bx", 12'(dut.bx), 12'd0);
    check("post_reset_by", 12'(dut.by), 12'd0);
    frame_pulse();
    check("post_reset_pulse_bx", 12'(dut.bx), 12'd1);
    check("post_reset_pulse_by", 12'(dut.by), 12'd1);

    // Button seen after two sync clocks, then four differing clocks: accepted on the 6th edge.
    mode_btn = 1'b1;
    step(5);
    frame_start = 1'b1;
    step(1);
    frame_start = 1'b0;
    check("coincide_mode_held", 12'(mode), 12'd0);
    check("coincide_pending", 12'(dut.pending_mode), 12'd1);
    mode_btn = 1'b0;
    step(10);
    frame_pulse();
    check("coincide_next_frame", 12'(mode), 12'd1);

    do_reset();
    press_btn();
    press_btn();
    frame_start = 1'b1;
    step(5);
    frame_start = 1'b0;
    check("box_mode", 12'(mode), 12'd2);
    check("box_bx5", 12'(dut.bx), 12'd5);
    check("box_by5", 12'(dut.by), 12'd5);
    pix("box_5_5",  5,  5, 1'b1, 3'b111);
    pix("box_4_5",  4,  5, 1'b1, 3'b001);
    pix("box_36_5", 36, 5, 1'b1, 3'b111);
    pix("box_37_5", 37, 5, 1'b1, 3'b001);

    frame_start = 1'b1;
    step(563);
    frame_start = 1'b0;
    check("by_at_568", 12'(dut.by), 12'd568);
    check("dy_fwd_568", 12'(dut.dy_neg), 12'd0);
    frame_pulse();
    check("by_bounce_567", 12'(dut.by), 12'd567);
    check("dy_neg_569", 12'(dut.dy_neg), 12'd1);

    frame_start = 1'b1;
    step(199);
    frame_start = 1'b0;
    check("bx_at_768", 12'(dut.bx), 12'd768);
    check("by_at_768", 12'(dut.by), 12'd368);
    frame_pulse();
    check("bx_bounce_767", 12'(dut.bx), 12'd767);
    check("dx_neg_769", 12'(dut.dx_neg), 12'd1);

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
